// File: rtl/i2s_tx.sv
// Philips I2S transmitter: sample FIFO, BCLK/LRCLK divider and 32-bit frame serializer.
// Each 32-bit sample {left, right} is sent MSB first, one BCLK after the LRCLK edge.
module i2s_tx #(
  parameter int unsigned CLK_DIV = 33,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        ready,
  output logic        valid,
  input  logic [31:0] sample_i,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic        overflow
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [DW-1:0] DivMax = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] Full   = CW'(DEPTH);

  logic [DW-1:0] r_div_cnt;
  logic          r_bclk;
  logic          r_lrclk;
  logic          r_sdata;
  logic          r_valid;
  logic          r_underrun;
  logic          r_overflow;
  logic          r_ready;
  logic [4:0]    r_bit_cnt;
  logic [31:0]   r_shifter;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_tick;
  logic          w_fall;
  logic          w_frame_start;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_bit_nxt;
  logic [CW-1:0] w_count_d;

  always_comb begin
    w_tick        = 1'b0;
    w_fall        = 1'b0;
    w_frame_start = 1'b0;
    w_full        = 1'b0;
    w_empty       = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_bit_nxt     = r_bit_cnt + 5'd1;
    w_count_d     = r_count;

    w_tick        = (r_div_cnt == DivMax);
    w_fall        = w_tick & r_bclk;
    w_frame_start = w_fall & (w_bit_nxt == 5'd0);
    w_full        = (r_count == Full);
    w_empty       = (r_count == '0);
    // Push is judged on the current count only, so a same-cycle pop never admits it when full.
    w_push        = en & ~w_full;
    w_pop         = w_frame_start & ~w_empty;

    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= 5'd31;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_shifter  <= '0;
      r_valid    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_valid    <= w_pop;
      r_underrun <= w_frame_start & w_empty;
      if (w_fall) begin
        // The outgoing bit is taken before the shifter loads, giving the one-BCLK delay.
        r_sdata   <= r_shifter[31];
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_bit_nxt[4];
        if (w_frame_start) begin
          r_shifter <= w_empty ? 32'd0 : r_mem[r_rd_ptr];
        end else begin
          r_shifter <= {r_shifter[30:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_d;
      r_ready    <= (w_count_d < Full);
      r_overflow <= en & w_full;
    end
  end

  // Storage needs no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= sample_i;
  end

  assign bclk     = r_bclk;
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign valid    = r_valid;
  assign underrun = r_underrun;
  assign overflow = r_overflow;
  assign ready    = r_ready;

endmodule
